// File: rtl/fpu_pkg.sv
// Shared FPU definitions: flag bit positions, fp32 field layout and the
// canonical quiet NaN. Used by the multiplier result stage and its FIFO.
package fpu_pkg;

  localparam int FLAG_W = 5;
  localparam int FLG_NV = 4;
  localparam int FLG_OF = 3;
  localparam int FLG_UF = 2;
  localparam int FLG_NX = 1;
  localparam int FLG_ZR = 0;

  localparam int FP_W   = 32;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  localparam int FP_SIGN_BIT = 31;
  localparam int FP_EXP_MSB  = 30;
  localparam int FP_EXP_LSB  = 23;
  localparam int FP_FRAC_MSB = 22;
  localparam int FP_FRAC_LSB = 0;

  localparam logic [FP_W-1:0] CANON_NAN = 32'h7FC0_0000;

  typedef logic [FP_W-1:0] fp32_t;

  // Places sign, exponent and fraction into their fp32 fields unchanged.
  function automatic fp32_t pack_fp32(input logic s,
                                      input logic [EXP_W-1:0] e,
                                      input logic [FRAC_W-1:0] m);
    fp32_t r;
    r = '0;
    r[FP_SIGN_BIT] = s;
    r[FP_EXP_MSB:FP_EXP_LSB] = e;
    r[FP_FRAC_MSB:FP_FRAC_LSB] = m;
    return r;
  endfunction

endpackage

// File: rtl/fpu_mul_result_stage_if.sv
// Result-stage bus: multiplier-side push interface, writeback-side pop
// interface, sticky flag status and occupancy. master = surrounding logic,
// slave = the result stage itself.
interface fpu_mul_result_stage_if #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic                     Sz;
  logic [7:0]               Ez;
  logic [22:0]              Mz;
  logic                     invalid_flag;
  logic                     overflow_flag;
  logic                     underflow_flag;
  logic                     inexact_flag;
  logic                     zero_flag;
  logic [TAG_W-1:0]         in_tag;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_result;
  logic [4:0]               out_flags;
  logic [TAG_W-1:0]         out_tag;
  logic [4:0]               sticky_flags;
  logic                     flags_clr;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output in_valid, Sz, Ez, Mz, invalid_flag, overflow_flag, underflow_flag,
           inexact_flag, zero_flag, in_tag, out_ready, flags_clr,
    input  in_ready, out_valid, out_result, out_flags, out_tag, sticky_flags, count
  );

  modport slave (
    input  in_valid, Sz, Ez, Mz, invalid_flag, overflow_flag, underflow_flag,
           inexact_flag, zero_flag, in_tag, out_ready, flags_clr,
    output in_ready, out_valid, out_result, out_flags, out_tag, sticky_flags, count
  );
endinterface

// File: rtl/fpu_res_fifo.sv
// Generic DEPTH x WIDTH register FIFO with wrapping pointers and a separate
// occupancy counter. Push is ignored when full, pop is ignored when empty,
// and there is no bypass from write to read port.
module fpu_res_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 41
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];
  assign count   = count_q;

  // Storage array is written on accepted pushes only and needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at DEPTH; count moves only when exactly one side fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/fpu_mul_result_stage.sv
// Multiplier result stage: packs Top_Mul outputs into an fp32 word, queues
// them with their flags and destination tag, and keeps sticky exception
// flags for retired results.
// Optional macro FPU_CANON_NAN_EN: results pushed with the invalid flag set
// are stored as the canonical quiet NaN instead of the raw Sz/Ez/Mz.
module fpu_mul_result_stage
  import fpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fpu_mul_result_stage_if.slave bus
);
  localparam int ENTRY_W = FP_W + FLAG_W + TAG_W;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic [FLAG_W-1:0]  in_flags;
  fp32_t              in_word;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [FLAG_W-1:0]  head_flags;
  logic [FLAG_W-1:0]  sticky_q;

  // Gather the individual exception flags into the stored flag vector.
  always_comb begin
    in_flags         = '0;
    in_flags[FLG_NV] = bus.invalid_flag;
    in_flags[FLG_OF] = bus.overflow_flag;
    in_flags[FLG_UF] = bus.underflow_flag;
    in_flags[FLG_NX] = bus.inexact_flag;
    in_flags[FLG_ZR] = bus.zero_flag;
  end

  // Pack the result word, optionally replacing invalid results by the canonical NaN.
  always_comb begin
    in_word = pack_fp32(bus.Sz, bus.Ez, bus.Mz);
`ifdef FPU_CANON_NAN_EN
    if (bus.invalid_flag) begin
      in_word = CANON_NAN;
    end
`endif
  end

  assign wr_entry = {in_word, in_flags, bus.in_tag};
  assign push     = bus.in_valid & ~full;
  assign pop      = bus.out_ready & ~empty;

  fpu_res_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (pop),
    .rd_data (rd_entry),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  assign head_flags = rd_entry[TAG_W +: FLAG_W];

  assign bus.in_ready     = ~full;
  assign bus.out_valid    = ~empty;
  assign bus.out_result   = empty ? '0 : rd_entry[ENTRY_W-1 -: FP_W];
  assign bus.out_flags    = empty ? '0 : head_flags;
  assign bus.out_tag      = empty ? '0 : rd_entry[TAG_W-1:0];
  assign bus.count        = fifo_count;
  assign bus.sticky_flags = sticky_q;

  // Accumulate flags of retired results; a clear in the same cycle as a pop acts first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= '0;
    end else if (pop) begin
      sticky_q <= (bus.flags_clr ? '0 : sticky_q) | head_flags;
    end else if (bus.flags_clr) begin
      sticky_q <= '0;
    end
  end
endmodule

// File: tb/tb_fpu_mul_result_stage.sv
// Scoreboard bench for fpu_mul_result_stage: the driver enqueues expected
// results as they are accepted, a negedge monitor compares each retired
// result plus occupancy, handshake and sticky flags against a queue model.
module tb_fpu_mul_result_stage;
  localparam int DEPTH = 2;
  localparam int TAG_W = 4;

  typedef struct {
    logic [31:0]      res;
    logic [4:0]       flg;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t sb[$];
  logic [4:0] sticky_model = 5'd0;
  bit model_ready = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpu_mul_result_stage_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

  fpu_mul_result_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: plain fp32 concatenation, or canonical NaN for invalid ops when enabled.
  function automatic logic [31:0] ref_result(input bit s, input logic [7:0] e,
                                             input logic [22:0] m, input bit inv);
`ifdef FPU_CANON_NAN_EN
    if (inv) return 32'h7FC0_0000;
`endif
    return {s, e, m};
  endfunction

  task automatic apply_stimulus(input bit valid, input bit s, input logic [7:0] e,
                                input logic [22:0] m, input logic [4:0] flags,
                                input logic [TAG_W-1:0] tag, input bit oready,
                                input bit clr);
    exp_t x;
    @(posedge clk);
    #1;
    bus.in_valid       = valid;
    bus.Sz             = s;
    bus.Ez             = e;
    bus.Mz             = m;
    bus.invalid_flag   = flags[4];
    bus.overflow_flag  = flags[3];
    bus.underflow_flag = flags[2];
    bus.inexact_flag   = flags[1];
    bus.zero_flag      = flags[0];
    bus.in_tag         = tag;
    bus.out_ready      = oready;
    bus.flags_clr      = clr;
    @(negedge clk);
    #1;
    if (valid && model_ready) begin
      x.res = ref_result(s, e, m, flags[4]);
      x.flg = flags;
      x.tag = tag;
      sb.push_back(x);
    end
  endtask

  task automatic idle(input bit oready, input bit clr);
    apply_stimulus(1'b0, 1'b0, 8'h00, 23'h0, 5'd0, '0, oready, clr);
  endtask

  // Monitor: compares DUT state against the queue model one half-cycle before each edge.
  initial begin
    exp_t e;
    bit pop_now;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check_output("count", 32'(bus.count), 32'(sb.size()));
        check_output("in_ready", 32'(bus.in_ready), 32'(sb.size() < DEPTH));
        check_output("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
        check_output("sticky_flags", 32'(bus.sticky_flags), 32'(sticky_model));
        model_ready = (sb.size() < DEPTH);
        pop_now = (sb.size() != 0) && bus.out_ready;
        if (sb.size() == 0) begin
          check_output("empty_result", bus.out_result, 32'h0);
          check_output("empty_tag", 32'(bus.out_tag), 32'h0);
        end else begin
          e = sb[0];
          check_output("out_result", bus.out_result, e.res);
          check_output("out_flags", 32'(bus.out_flags), 32'(e.flg));
          check_output("out_tag", 32'(bus.out_tag), 32'(e.tag));
        end
        if (pop_now) begin
          e = sb.pop_front();
          sticky_model = (bus.flags_clr ? 5'd0 : sticky_model) | e.flg;
        end else if (bus.flags_clr) begin
          sticky_model = 5'd0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int drain;
    bus.in_valid = 0; bus.Sz = 0; bus.Ez = 0; bus.Mz = 0;
    bus.invalid_flag = 0; bus.overflow_flag = 0; bus.underflow_flag = 0;
    bus.inexact_flag = 0; bus.zero_flag = 0; bus.in_tag = 0;
    bus.out_ready = 0; bus.flags_clr = 0;

    // Reset state
    #12;
    check_output("rst_count", 32'(bus.count), 32'd0);
    check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_output("rst_sticky", 32'(bus.sticky_flags), 32'd0);
    check_output("rst_result", bus.out_result, 32'd0);
    #1 rst_n = 1'b1;

    // Single result
    apply_stimulus(1, 1'b0, 8'h8E, 23'h7FFFFF, 5'b00000, 4'd3, 1, 0);
    idle(1, 0);
    idle(1, 0);

    // Fill to full, extra push ignored, then drain in order
    apply_stimulus(1, 1'b0, 8'h10, 23'h000111, 5'b00000, 4'd1, 0, 0);
    apply_stimulus(1, 1'b1, 8'h20, 23'h000222, 5'b00000, 4'd2, 0, 0);
    apply_stimulus(1, 1'b0, 8'h30, 23'h000333, 5'b00000, 4'd7, 0, 0);
    idle(1, 0);
    idle(1, 0);
    idle(1, 0);

    // Streaming with wrap-around
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1, 1'($urandom), 8'($urandom), 23'($urandom), 5'd0,
                     TAG_W'(i), 1, 0);
    end
    idle(1, 0);
    idle(1, 0);

    // Sticky accumulation and clear-with-pop
    apply_stimulus(1, 1'b0, 8'h7F, 23'h0, 5'b01010, 4'd4, 1, 0);
    apply_stimulus(1, 1'b0, 8'h00, 23'h0, 5'b00001, 4'd5, 1, 0);
    idle(1, 0);
    apply_stimulus(1, 1'b1, 8'h01, 23'h1, 5'b10000, 4'd6, 0, 0);
    idle(1, 1);
    idle(0, 0);
    idle(0, 1);

    // Invalid operation result
    apply_stimulus(1, 1'b1, 8'hFF, 23'h000001, 5'b10000, 4'd9, 1, 0);
    idle(1, 0);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      apply_stimulus(1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom),
                     23'($urandom), 5'($urandom), TAG_W'($urandom),
                     1'($urandom), $urandom_range(0, 7) == 0);
    end
    drain = 0;
    while (sb.size() != 0 && drain < 20) begin
      idle(1, 0);
      drain++;
    end
    check_output("drain", 32'(sb.size()), 32'd0);

    // Asynchronous reset while full with sticky flags set
    apply_stimulus(1, 1'b0, 8'h55, 23'h5, 5'b11111, 4'd8, 1, 0);
    idle(1, 0);
    apply_stimulus(1, 1'b0, 8'h66, 23'h6, 5'b00100, 4'd10, 0, 0);
    apply_stimulus(1, 1'b1, 8'h77, 23'h7, 5'b00010, 4'd11, 0, 0);
    @(posedge clk);
    #2;
    check_output("pre_reset_count", 32'(bus.count), 32'd2);
    #1;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_output("async_count", 32'(bus.count), 32'd0);
    check_output("async_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("async_sticky", 32'(bus.sticky_flags), 32'd0);
    check_output("async_in_ready", 32'(bus.in_ready), 32'd1);
    sb.delete();
    sticky_model = 5'd0;
    model_ready = 1'b1;
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Recovery after reset
    apply_stimulus(1, 1'b0, 8'h3F, 23'h400000, 5'b00010, 4'd12, 1, 0);
    idle(1, 0);
    idle(1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
